// File: rtl/pe_instr_sequencer_pkg.sv
// rtl/pe_instr_sequencer_pkg.sv - shared state encoding and program-length helper for the PE sequencer
package pe_instr_sequencer_pkg;

  // Sequencer states; encodings are shared with the control plane.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Clamp a requested program length to the buffer depth so pc never
  // addresses past the last buffer entry.
  function automatic logic [31:0] sat_prog_len(input logic [31:0] len,
                                               input int unsigned addr_len);
    logic [31:0] depth;
    depth = 32'd1 << addr_len;
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/pe_instr_sequencer_counter.sv
// rtl/pe_instr_sequencer_counter.sv - clearable wrap counter used for pc and iteration count
module pe_seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = (cnt_q == max);
  assign cnt  = cnt_q;

  // Next count: clear wins, otherwise step and fold back to 0 after max.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pe_instr_sequencer.sv
// rtl/pe_instr_sequencer.sv - walks one PE instruction buffer through progLen x numIter reads
module pe_instr_sequencer
  import pe_instr_sequencer_pkg::*;
#(
  parameter int addrLen = 5,
  parameter int iterLen = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [addrLen:0]   progLen,
  input  logic [iterLen-1:0] numIter,
  input  logic               stallIn,
  output logic [addrLen-1:0] rdAddr,
  output logic               noStall,
  output logic               instValid,
  output logic               lastInst,
  output logic               busy,
  output logic               done
);

  localparam int PL_W = addrLen + 1;

  seq_state_e         state_q, state_d;
  logic [PL_W-1:0]    prog_len_q, prog_len_d;
  logic [iterLen-1:0] num_iter_q, num_iter_d;
  logic               inst_valid_q, inst_valid_d;
  logic               last_inst_q, last_inst_d;

  logic               adv;
  logic [PL_W-1:0]    prog_len_sat;
  logic               pc_clr, pc_en, pc_wrap;
  logic [PL_W-1:0]    pc_cnt;
  logic               iter_clr, iter_en, iter_wrap;
  logic [iterLen-1:0] iter_cnt_unused;
  logic               pc_msb_unused;

  assign adv          = ~stallIn;
  assign noStall      = ~stallIn;
  assign prog_len_sat = PL_W'(sat_prog_len(32'(progLen), addrLen));

  pe_seq_counter #(.W(PL_W)) u_pc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (pc_clr),
    .en   (pc_en),
    .max  (prog_len_q - PL_W'(1)),
    .cnt  (pc_cnt),
    .wrap (pc_wrap)
  );

  pe_seq_counter #(.W(iterLen)) u_iter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (iter_clr),
    .en   (iter_en),
    .max  (num_iter_q - iterLen'(1)),
    .cnt  (iter_cnt_unused),
    .wrap (iter_wrap)
  );

  // pc top bit is only needed for the full-width compare inside the counter;
  // saturation keeps pc below the buffer depth.
  assign pc_msb_unused = pc_cnt[addrLen];

  assign rdAddr    = (state_q == RUN) ? pc_cnt[addrLen-1:0] : '0;
  assign instValid = inst_valid_q;
  assign lastInst  = last_inst_q;
  assign busy      = (state_q == RUN) || (state_q == FLUSH);
  assign done      = (state_q == DONE);

  // Next-state, counter control and output-strobe logic.
  always_comb begin
    state_d      = state_q;
    prog_len_d   = prog_len_q;
    num_iter_d   = num_iter_q;
    inst_valid_d = inst_valid_q;
    last_inst_d  = last_inst_q;
    pc_clr       = 1'b0;
    pc_en        = 1'b0;
    iter_clr     = 1'b0;
    iter_en      = 1'b0;
    case (state_q)
      IDLE: begin
        pc_clr   = 1'b1;
        iter_clr = 1'b1;
        if (start) begin
          prog_len_d = prog_len_sat;
          num_iter_d = numIter;
          if ((prog_len_sat == '0) || (numIter == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (adv) begin
          inst_valid_d = 1'b1;
          last_inst_d  = pc_wrap && iter_wrap;
          pc_en        = 1'b1;
          if (pc_wrap) begin
            if (iter_wrap) begin
              state_d = FLUSH;
            end else begin
              iter_en = 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          inst_valid_d = 1'b0;
          last_inst_d  = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched program shape and strobe registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      prog_len_q   <= '0;
      num_iter_q   <= '0;
      inst_valid_q <= 1'b0;
      last_inst_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_len_q   <= prog_len_d;
      num_iter_q   <= num_iter_d;
      inst_valid_q <= inst_valid_d;
      last_inst_q  <= last_inst_d;
    end
  end

endmodule

// File: tb/tb_pe_instr_sequencer.sv
// tb/tb_pe_instr_sequencer.sv - directed bench for pe_instr_sequencer with a behavioural buffer
module tb_pe_instr_sequencer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [5:0]  prog_len;
  logic [15:0] num_iter;
  logic        stall_in;
  logic [4:0]  rd_addr;
  logic        no_stall;
  logic        inst_valid;
  logic        last_inst;
  logic        busy;
  logic        done;

  logic [7:0]  mem [32];
  logic [7:0]  data_out;

  int checks;
  int failures;
  int cyc;
  int start_cyc;
  int lat;
  int done_cnt;
  bit busy_seen;
  int data_q[$];
  int last_q[$];

  pe_instr_sequencer #(.addrLen(5), .iterLen(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .progLen   (prog_len),
    .numIter   (num_iter),
    .stallIn   (stall_in),
    .rdAddr    (rd_addr),
    .noStall   (no_stall),
    .instValid (inst_valid),
    .lastInst  (last_inst),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 100);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (no_stall) data_out <= mem[rd_addr];
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (inst_valid && !stall_in) begin
        data_q.push_back(int'(data_out));
        last_q.push_back(int'(last_inst));
      end
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    data_q.delete();
    last_q.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic launch(input logic [5:0] pl, input logic [15:0] ni);
    prog_len  = pl;
    num_iter  = ni;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int latency);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    latency = found ? (cyc - start_cyc) : -1;
  endtask

  task automatic check_stream(input string tag, input int n, input int period);
    chk({tag, "_count"}, 32'(data_q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_data%0d", tag, k), 32'(data_q[k]), 32'(100 + (k % period)));
      chk($sformatf("%s_last%0d", tag, k), 32'(last_q[k]), 32'(k == n - 1));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rstn     = 1'b0;
    start    = 1'b0;
    prog_len = '0;
    num_iter = '0;
    stall_in = 1'b0;
    clear_logs();

    // reset state
    repeat (2) tick();
    chk("rst_rdaddr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_last", 32'(last_inst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_nostall0", 32'(no_stall), 32'd1);
    stall_in = 1'b1;
    #1;
    chk("rst_nostall1", 32'(no_stall), 32'd0);
    stall_in = 1'b0;
    rstn = 1'b1;
    tick();

    // 1: single pass of four
    clear_logs();
    launch(6'd4, 16'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rdaddr0", 32'(rd_addr), 32'd0);
    wait_done("t1", 200, lat);
    chk("t1_latency", 32'(lat), 32'd6);
    tick();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_stream("t1", 4, 4);

    // 2: two passes of three
    clear_logs();
    launch(6'd3, 16'd2);
    wait_done("t2", 200, lat);
    chk("t2_latency", 32'(lat), 32'd8);
    tick();
    check_stream("t2", 6, 3);

    // 3: three-cycle stall while 101 is on dataOut
    clear_logs();
    launch(6'd4, 16'd1);
    tick();
    tick();
    chk("t3_pre_data", 32'(data_out), 32'd101);
    stall_in = 1'b1;
    #1;
    chk("t3_nostall", 32'(no_stall), 32'd0);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("t3_hold_addr%0d", s), 32'(rd_addr), 32'd2);
      tick();
      chk($sformatf("t3_hold_data%0d", s), 32'(data_out), 32'd101);
    end
    stall_in = 1'b0;
    wait_done("t3", 200, lat);
    chk("t3_latency", 32'(lat), 32'd9);
    tick();
    check_stream("t3", 4, 4);

    // 4: zero progLen or zero numIter
    clear_logs();
    launch(6'd0, 16'd5);
    wait_done("t4a", 20, lat);
    chk("t4a_latency", 32'(lat), 32'd1);
    tick();
    chk("t4a_valid_cnt", 32'(data_q.size()), 32'd0);
    chk("t4a_busy_seen", 32'(busy_seen), 32'd0);
    clear_logs();
    launch(6'd7, 16'd0);
    wait_done("t4b", 20, lat);
    chk("t4b_latency", 32'(lat), 32'd1);
    tick();
    chk("t4b_valid_cnt", 32'(data_q.size()), 32'd0);
    chk("t4b_busy_seen", 32'(busy_seen), 32'd0);

    // 5: start while busy and on the done cycle
    clear_logs();
    launch(6'd4, 16'd1);
    tick();
    tick();
    prog_len = 6'd2;
    num_iter = 16'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 200, lat);
    chk("t5_latency", 32'(lat), 32'd6);
    prog_len = 6'd2;
    num_iter = 16'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_busy_after", 32'(busy), 32'd0);
    check_stream("t5", 4, 4);

    // 6: reset mid-run at rdAddr=2
    clear_logs();
    launch(6'd4, 16'd1);
    tick();
    tick();
    chk("t6_addr_before", 32'(rd_addr), 32'd2);
    rstn = 1'b0;
    #1;
    chk("t6_rst_rdaddr", 32'(rd_addr), 32'd0);
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_last", 32'(last_inst), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    tick();
    rstn = 1'b1;
    clear_logs();
    repeat (4) tick();
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    launch(6'd2, 16'd1);
    chk("t6_restart_addr", 32'(rd_addr), 32'd0);
    wait_done("t6", 200, lat);
    chk("t6_latency", 32'(lat), 32'd4);
    tick();
    check_stream("t6", 2, 2);

    // 7: progLen=40 saturates to 32, two passes
    clear_logs();
    launch(6'd40, 16'd2);
    wait_done("t7", 400, lat);
    chk("t7_latency", 32'(lat), 32'd66);
    tick();
    check_stream("t7", 64, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
